branch_flush_ctrl: RTL and testbench

Pipeline redirect and hazard controller for the 5-stage RV32I core. It consumes the EX-stage branch-comparator result (`br_taken`), jump indication and target address. It drives PC redirect, IF/ID/EX stall and flush controls, and defers a redirect while the memory/UART path holds the pipeline. Static not-taken policy: every taken branch or jump costs two flushed slots. It also keeps resolved/taken branch counters for software profiling over UART.

---
 rtl/branch_flush_ctrl_if.sv | 45 ++++
 rtl/branch_flush_ctrl.sv | 128 ++++++++++++
 tb/tb_branch_flush_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_flush_ctrl_if.sv
// Pipeline control bundle between the EX/ID/MEM stages and the redirect/hazard
// controller. The controller sits on the slave side; the pipeline (or a bench)
// sits on the master side.
interface branch_flush_ctrl_if #(
    parameter int CNT_W = 32
);
    // Qualification rule: ex_is_branch, ex_is_jump, br_taken and br_target
    // carry meaning only in a cycle where ex_valid=1. There is no ready
    // back-pressure on these inputs; mem_busy is the single global stall
    // request, and the controller answers it through the stall_* outputs in
    // the same cycle.
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_is_jump;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             load_use;
    logic             mem_busy;
    logic             cnt_clr;

    logic             pc_sel;
    logic [31:0]      pc_target;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             flush_id;
    logic             flush_ex;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;
    logic             state_dbg;   // 1 while a redirect is held pending

    modport master (
        output ex_valid, ex_is_branch, ex_is_jump, br_taken, br_target,
        output load_use, mem_busy, cnt_clr,
        input  pc_sel, pc_target, stall_if, stall_id, stall_ex,
        input  flush_id, flush_ex, br_count, taken_count, state_dbg
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jump, br_taken, br_target,
        input  load_use, mem_busy, cnt_clr,
        output pc_sel, pc_target, stall_if, stall_id, stall_ex,
        output flush_id, flush_ex, br_count, taken_count, state_dbg
    );
endinterface

// File: rtl/branch_flush_ctrl.sv
// Redirect and hazard controller for the 5-stage core. Static not-taken:
// a taken branch/jump in EX redirects the PC and flushes IF/ID and ID/EX.
// If the MEM stage is busy the redirect is parked in HOLD until it frees up.
// Also counts resolved and taken branches for software profiling.
module branch_flush_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_flush_ctrl_if.slave bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pend_target;
    logic [31:0] aligned_target;
    logic        take;
    logic        resolve;
    logic        latch_pend;
    logic        br_inc;
    logic        taken_inc;

    // A jump wins over a simultaneous branch flag and is always taken.
    assign take    = bus.ex_valid & (bus.ex_is_jump | (bus.ex_is_branch & bus.br_taken));
    assign resolve = bus.ex_valid & (bus.ex_is_branch | bus.ex_is_jump);
    assign aligned_target = {bus.br_target[31:1], 1'b0};

    assign bus.state_dbg = (state == HOLD);

    // Next-state and combinational control outputs.
    always_comb begin
        state_nxt     = state;
        latch_pend    = 1'b0;
        br_inc        = 1'b0;
        taken_inc     = 1'b0;
        bus.pc_sel    = 1'b0;
        bus.pc_target = aligned_target;
        bus.stall_if  = 1'b0;
        bus.stall_id  = 1'b0;
        bus.stall_ex  = 1'b0;
        bus.flush_id  = 1'b0;
        bus.flush_ex  = 1'b0;

        case (state)
            RUN: begin
                if (bus.mem_busy) begin
                    // Global stall dominates; a taken branch is parked and
                    // counted now so HOLD never has to count it.
                    bus.stall_if = 1'b1;
                    bus.stall_id = 1'b1;
                    bus.stall_ex = 1'b1;
                    if (take) begin
                        latch_pend = 1'b1;
                        br_inc     = 1'b1;
                        taken_inc  = 1'b1;
                        state_nxt  = HOLD;
                    end
                end else if (take) begin
                    // Load-use is irrelevant here: its ID instruction is flushed.
                    bus.pc_sel   = 1'b1;
                    bus.flush_id = 1'b1;
                    bus.flush_ex = 1'b1;
                    br_inc       = 1'b1;
                    taken_inc    = 1'b1;
                end else begin
                    br_inc = resolve;
                    if (bus.load_use) begin
                        bus.stall_if = 1'b1;
                        bus.stall_id = 1'b1;
                        bus.flush_ex = 1'b1;
                    end
                end
            end
            HOLD: begin
                // EX inputs and load_use are ignored while the redirect waits.
                if (bus.mem_busy) begin
                    bus.stall_if = 1'b1;
                    bus.stall_id = 1'b1;
                    bus.stall_ex = 1'b1;
                end else begin
                    bus.pc_sel    = 1'b1;
                    bus.pc_target = pend_target;
                    bus.flush_id  = 1'b1;
                    bus.flush_ex  = 1'b1;
                    state_nxt     = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // State register and parked redirect address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pend_target <= 32'd0;
        end else begin
            state <= state_nxt;
            if (latch_pend) begin
                pend_target <= aligned_target;
            end
        end
    end

    // Profiling counters; clear beats a same-cycle increment, wrap is natural.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.br_count    <= '0;
            bus.taken_count <= '0;
        end else if (bus.cnt_clr) begin
            bus.br_count    <= '0;
            bus.taken_count <= '0;
        end else begin
            if (br_inc) begin
                bus.br_count <= bus.br_count + CNT_W'(1);
            end
            if (taken_inc) begin
                bus.taken_count <= bus.taken_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Bench for branch_flush_ctrl (CNT_W=4 build so counter wrap is reachable).
// A spec-level model predicts every output on every falling edge; directed
// literal checks pin the model on the key scenarios.
module tb_branch_flush_ctrl;

    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;

    branch_flush_ctrl_if #(.CNT_W(CNT_W)) bus ();

    branch_flush_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];   // expected redirect addresses, in order

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=0x%0h expected=0x%0h", name, $time, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drv(input logic v, input logic b, input logic j, input logic t,
                       input logic [31:0] tgt, input logic lu, input logic bs,
                       input logic clr);
        bus.ex_valid     = v;
        bus.ex_is_branch = b;
        bus.ex_is_jump   = j;
        bus.br_taken     = t;
        bus.br_target    = tgt;
        bus.load_use     = lu;
        bus.mem_busy     = bs;
        bus.cnt_clr      = clr;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model state
    logic             m_pend;
    logic [31:0]      m_pt;
    logic [CNT_W-1:0] m_br;
    logic [CNT_W-1:0] m_tk;

    // Per-cycle compare against the model, sampled on the falling edge
    initial begin
        logic e_take, e_res, e_sel, e_sif, e_sid, e_sex, e_fid, e_fex;
        logic [31:0] e_tgt;
        logic [31:0] got;
        m_pend = 1'b0;
        m_pt   = 32'h0;
        m_br   = '0;
        m_tk   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pend = 1'b0;
                m_pt   = 32'h0;
                m_br   = '0;
                m_tk   = '0;
            end
            e_take = bus.ex_valid & (bus.ex_is_jump | (bus.ex_is_branch & bus.br_taken));
            e_res  = bus.ex_valid & (bus.ex_is_branch | bus.ex_is_jump);
            {e_sel, e_sif, e_sid, e_sex, e_fid, e_fex} = 6'b0;
            e_tgt = {bus.br_target[31:1], 1'b0};
            if (m_pend) begin
                if (bus.mem_busy) {e_sif, e_sid, e_sex} = 3'b111;
                else begin
                    e_sel = 1; e_tgt = m_pt; {e_fid, e_fex} = 2'b11;
                end
            end else if (bus.mem_busy) begin
                {e_sif, e_sid, e_sex} = 3'b111;
            end else if (e_take) begin
                e_sel = 1; {e_fid, e_fex} = 2'b11;
            end else if (bus.load_use) begin
                e_sif = 1; e_sid = 1; e_fex = 1;
            end
            if (e_sel) exp_q.push_back(e_tgt);

            chk("m_pc_sel",   32'(bus.pc_sel),   32'(e_sel));
            chk("m_pc_target", bus.pc_target,    e_tgt);
            chk("m_stall_if", 32'(bus.stall_if), 32'(e_sif));
            chk("m_stall_id", 32'(bus.stall_id), 32'(e_sid));
            chk("m_stall_ex", 32'(bus.stall_ex), 32'(e_sex));
            chk("m_flush_id", 32'(bus.flush_id), 32'(e_fid));
            chk("m_flush_ex", 32'(bus.flush_ex), 32'(e_fex));
            chk("m_br_count", 32'(bus.br_count), 32'(m_br));
            chk("m_taken_count", 32'(bus.taken_count), 32'(m_tk));
            chk("m_hold_dbg", 32'(bus.state_dbg), 32'(m_pend));

            // Scoreboard: every DUT redirect must match the next expected address
            if (bus.pc_sel === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL redirect_q t=%0t actual=0x%0h expected=none", $time, bus.pc_target);
                end else begin
                    got = exp_q.pop_front();
                    chk("sb_redirect", bus.pc_target, got);
                end
            end

            // Advance model to the next edge
            if (rst_n) begin
                if (bus.cnt_clr) begin
                    m_br = '0;
                    m_tk = '0;
                end else if (!m_pend) begin
                    if (e_res && (e_take || !bus.mem_busy)) m_br = m_br + 1'b1;
                    if (e_take) m_tk = m_tk + 1'b1;
                end
                if (m_pend) begin
                    if (!bus.mem_busy) m_pend = 1'b0;
                end else if (bus.mem_busy && e_take) begin
                    m_pend = 1'b1;
                    m_pt   = {bus.br_target[31:1], 1'b0};
                end
            end
        end
    end

    // Directed stimulus with literal expectations
    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        chk("rst_pc_sel", 32'(bus.pc_sel), 32'd0);
        chk("rst_stalls", 32'({bus.stall_if, bus.stall_id, bus.stall_ex}), 32'd0);
        chk("rst_flushes", 32'({bus.flush_id, bus.flush_ex}), 32'd0);
        chk("rst_br_count", 32'(bus.br_count), 32'd0);
        chk("rst_taken_count", 32'(bus.taken_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Taken branch, not busy: same-cycle redirect
        cyc(); drv(1, 1, 0, 1, 32'h100, 0, 0, 0);
        #2;
        chk("tk_pc_sel", 32'(bus.pc_sel), 32'd1);
        chk("tk_pc_target", bus.pc_target, 32'h100);
        chk("tk_flushes", 32'({bus.flush_id, bus.flush_ex}), 32'd3);
        cyc(); idle();
        #2;
        chk("tk_br_count", 32'(bus.br_count), 32'd1);
        chk("tk_taken_count", 32'(bus.taken_count), 32'd1);

        // Clear, not-taken branch, then JALR to an odd address
        cyc(); drv(0, 0, 0, 0, 32'h0, 0, 0, 1);
        cyc(); drv(1, 1, 0, 0, 32'h300, 0, 0, 0);
        #2;
        chk("nt_pc_sel", 32'(bus.pc_sel), 32'd0);
        cyc(); drv(1, 0, 1, 0, 32'h203, 0, 0, 0);
        #2;
        chk("jalr_pc_target", bus.pc_target, 32'h202);
        cyc(); idle();
        #2;
        chk("jalr_br_count", 32'(bus.br_count), 32'd2);
        chk("jalr_taken_count", 32'(bus.taken_count), 32'd1);

        // Taken branch while MEM busy for 3 cycles, target changed during HOLD
        cyc(); drv(0, 0, 0, 0, 32'h0, 0, 0, 1);
        cyc(); drv(1, 1, 0, 1, 32'h40, 0, 1, 0);
        #2;
        chk("hold1_stalls", 32'({bus.stall_if, bus.stall_id, bus.stall_ex}), 32'd7);
        chk("hold1_pc_sel", 32'(bus.pc_sel), 32'd0);
        cyc(); drv(1, 0, 1, 0, 32'h80, 1, 1, 0);
        #2;
        chk("hold2_stalls", 32'({bus.stall_if, bus.stall_id, bus.stall_ex}), 32'd7);
        chk("hold2_br_count", 32'(bus.br_count), 32'd1);
        cyc(); drv(0, 0, 0, 0, 32'h80, 0, 1, 0);
        #2;
        chk("hold3_pc_sel", 32'(bus.pc_sel), 32'd0);
        cyc(); drv(1, 0, 1, 0, 32'h80, 1, 0, 0);
        #2;
        chk("hold_exit_pc_sel", 32'(bus.pc_sel), 32'd1);
        chk("hold_exit_target", bus.pc_target, 32'h40);
        chk("hold_exit_flush", 32'({bus.flush_id, bus.flush_ex}), 32'd3);
        chk("hold_exit_stalls", 32'({bus.stall_if, bus.stall_id, bus.stall_ex}), 32'd0);
        cyc(); idle();
        #2;
        chk("hold_pc_sel_after", 32'(bus.pc_sel), 32'd0);
        chk("hold_br_count", 32'(bus.br_count), 32'd1);
        chk("hold_taken_count", 32'(bus.taken_count), 32'd1);

        // Load-use alone, then with a taken jump
        cyc(); drv(0, 0, 0, 0, 32'h0, 1, 0, 0);
        #2;
        chk("lu_ctrl", 32'({bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_id, bus.flush_ex}), 32'b11001);
        cyc(); drv(1, 0, 1, 0, 32'h500, 1, 0, 0);
        #2;
        chk("lu_jmp_ctrl", 32'({bus.pc_sel, bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_id, bus.flush_ex}), 32'b100011);

        // Reset in the middle of HOLD
        cyc(); drv(1, 0, 1, 0, 32'h600, 0, 1, 0);
        cyc(); drv(0, 0, 0, 0, 32'h0, 0, 1, 0);
        #1;
        rst_n = 1'b0;
        idle();
        #1;
        chk("mid_rst_ctrl", 32'({bus.pc_sel, bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_id, bus.flush_ex}), 32'd0);
        chk("mid_rst_counts", 32'({bus.br_count, bus.taken_count}), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        #2;
        chk("post_rst_pc_sel", 32'(bus.pc_sel), 32'd0);
        cyc();
        #2;
        chk("post_rst_pc_sel2", 32'(bus.pc_sel), 32'd0);

        // Counter wrap and clear priority
        cyc(); drv(0, 0, 0, 0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            cyc(); drv(1, 0, 1, 0, 32'h1000 + 32'(i) * 4, 0, 0, 0);
        end
        cyc(); idle();
        #2;
        chk("wrap_pre_br", 32'(bus.br_count), 32'd15);
        chk("wrap_pre_taken", 32'(bus.taken_count), 32'd15);
        cyc(); drv(1, 0, 1, 0, 32'h2000, 0, 0, 0);
        cyc(); idle();
        #2;
        chk("wrap_br", 32'(bus.br_count), 32'd0);
        chk("wrap_taken", 32'(bus.taken_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(); drv(1, 0, 1, 0, 32'h3000, 0, 0, 0);
        end
        cyc(); drv(1, 0, 1, 0, 32'h3004, 0, 0, 1);
        cyc(); idle();
        #2;
        chk("clr_br", 32'(bus.br_count), 32'd0);
        chk("clr_taken", 32'(bus.taken_count), 32'd0);

        repeat (2) cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        n_cmp++;
        n_bad++;
        $display("FAIL timeout t=%0t actual=running expected=finished", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
